// File: rtl/load_align_unit.sv
// Load data path: issues one or two word-aligned bus reads, aligns and sign/zero-extends the result.
// Define MISALIGNED_SPLIT_EN to perform word-crossing loads as two beats; otherwise they fault.
module load_align_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_fault
);
   localparam int NB    = XLEN / 8;
   localparam int OFS_W = $clog2(NB);
   localparam int SW    = OFS_W + 2;
   localparam logic [SW-1:0] NB_S = SW'(NB);

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      WAIT0,
`ifdef MISALIGNED_SPLIT_EN
      REQ1,
      WAIT1,
`endif
      RESP
   } state_t;

   state_t state, state_next;

   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        f3_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic              fault_reg;
   logic [XLEN-1:0]   beat0, beat1;
   logic              legal, cross_req, fault_req;
   logic [3:0]        size_req;
   logic [SW-1:0]     end_ofs;
   logic [ADDR_W-1:0] word_addr;
   logic [XLEN-1:0]   shifted, ext;
   logic              top;
   int                nbits;

   always_comb begin
      legal    = 1'b1;
      size_req = 4'd1;
      case (req_funct3)
         3'b000, 3'b100: size_req = 4'd1;
         3'b001, 3'b101: size_req = 4'd2;
         3'b010:         size_req = 4'd4;
         3'b011: begin size_req = 4'd8; legal = (XLEN == 64); end
         3'b110: begin size_req = 4'd4; legal = (XLEN == 64); end
         default: legal = 1'b0;
      endcase
      end_ofs   = SW'(req_addr[OFS_W-1:0]) + SW'(size_req);
      cross_req = end_ofs > NB_S;
`ifdef MISALIGNED_SPLIT_EN
      fault_req = !legal;
`else
      fault_req = !legal || cross_req;
`endif
   end

`ifdef MISALIGNED_SPLIT_EN
   logic cross_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         cross_reg <= 1'b0;
      else if (state == IDLE && req_valid) cross_reg <= cross_req;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   assign word_addr = {addr_reg[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = fault_req ? RESP : REQ0;
         end
         REQ0: begin
            mem_req  = 1'b1;
            mem_addr = word_addr;
            if (mem_gnt) state_next = WAIT0;
         end
         WAIT0: begin
`ifdef MISALIGNED_SPLIT_EN
            if (mem_rvalid) state_next = cross_reg ? REQ1 : RESP;
`else
            if (mem_rvalid) state_next = RESP;
`endif
         end
`ifdef MISALIGNED_SPLIT_EN
         REQ1: begin
            mem_req  = 1'b1;
            mem_addr = word_addr + ADDR_W'(NB);
            if (mem_gnt) state_next = WAIT1;
         end
         WAIT1: if (mem_rvalid) state_next = RESP;
`endif
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Beat buffers are cleared on accept so a non-crossing load sees beat1 = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         f3_reg    <= '0;
         tag_reg   <= '0;
         fault_reg <= 1'b0;
         beat0     <= '0;
         beat1     <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            addr_reg  <= req_addr;
            f3_reg    <= req_funct3;
            tag_reg   <= req_tag;
            fault_reg <= fault_req;
            beat0     <= '0;
            beat1     <= '0;
         end
         if (state == WAIT0 && mem_rvalid) beat0 <= mem_rdata;
`ifdef MISALIGNED_SPLIT_EN
         if (state == WAIT1 && mem_rvalid) beat1 <= mem_rdata;
`endif
      end
   end

   always_comb begin
      shifted = XLEN'({beat1, beat0} >> {addr_reg[OFS_W-1:0], 3'b000});
      nbits   = 8 << f3_reg[1:0];
      case (f3_reg[1:0])
         2'd0:    top = shifted[7];
         2'd1:    top = shifted[15];
         2'd2:    top = shifted[31];
         default: top = shifted[XLEN-1];
      endcase
      ext = shifted;
      // funct3[2] marks the unsigned forms; LD never needs extension.
      for (int i = 0; i < XLEN; i++)
         if (i >= nbits) ext[i] = top & ~f3_reg[2];
   end

   assign rsp_valid = (state == RESP);
   assign rsp_fault = (state == RESP) && fault_reg;
   assign rsp_data  = (state == RESP && !fault_reg) ? ext : '0;
   assign rsp_tag   = tag_reg;

endmodule
